// File: rtl/arb_pri8.sv
// arb_pri8: eight-requester arbiter with a registered one-hot grant, an encoded index and a bounded hold time.
// Optional build macro ARB_PRI8_ROUND_ROBIN_EN replaces fixed priority 7..0 with rotating priority after the last owner.
module arb_pri8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic [7:0] hold_cnt,
  output logic       state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] start;
  logic [3:0] win;
  logic       do_grant;

`ifdef ARB_PRI8_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;
`endif

  // Returns {found, index}. The search visits start-1, start-2, ... wrapping
  // through 7 and ends at start, so start=0 gives plain priority 7..0.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] s);
    logic [3:0] res;
    logic [2:0] i;
    res = 4'b0000;
    for (int k = 8; k >= 1; k--) begin
      i = s - 3'(k);
      if (r[i]) res = {1'b1, i};
    end
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    win      = 4'b0000;
    do_grant = 1'b0;
`ifdef ARB_PRI8_ROUND_ROBIN_EN
    ptr_d    = ptr_q;
    start    = ptr_q;
`else
    start    = 3'd0;
`endif

    case (state_q)
      IDLE: begin
        if (|req) begin
          win      = pick(req, start);
          do_grant = 1'b1;
        end
      end
      BUSY: begin
        if (!req[idx_q]) begin
          win = pick(req, start);
          if (win[3]) begin
            do_grant = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'h00;
            idx_d   = 3'd0;
            hold_d  = 8'd0;
          end
        end else if (hold_q == 8'(MAX_HOLD)) begin
          // Time is up: everyone but the owner gets first chance; a lone owner is re-granted.
          win = pick(req & ~gnt_q, start);
          if (!win[3]) win = {1'b1, idx_q};
          do_grant = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_grant) begin
      state_d = BUSY;
      gnt_d   = 8'b0000_0001 << win[2:0];
      idx_d   = win[2:0];
      hold_d  = 8'd1;
`ifdef ARB_PRI8_ROUND_ROBIN_EN
      ptr_d   = win[2:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 8'h00;
      idx_q   <= 3'd0;
      hold_q  <= 8'd0;
`ifdef ARB_PRI8_ROUND_ROBIN_EN
      ptr_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
`ifdef ARB_PRI8_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == BUSY);
  assign hold_cnt  = hold_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_arb_pri8.sv
// Directed bench for arb_pri8 built with MAX_HOLD=4: reset, priority, handover, forced release,
// async reset mid-grant and the drop-and-reassert rotation sequence.
module tb_arb_pri8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic [7:0] hold_cnt;
  logic       state_dbg;

  int total = 0;
  int bad   = 0;

  arb_pri8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .hold_cnt  (hold_cnt),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the expected owner (or idle when exp_v=0).
  task automatic chk(input string tag, input logic exp_v, input logic [2:0] exp_i,
                     input logic [7:0] exp_h);
    logic [7:0] exp_g;
    logic [2:0] exp_x;
    exp_g = exp_v ? (8'b0000_0001 << exp_i) : 8'h00;
    exp_x = exp_v ? exp_i : 3'd0;
    total++;
    assert (gnt === exp_g) else begin
      bad++;
      $error("FAIL %s gnt: observed=%h expected=%h", tag, gnt, exp_g);
    end
    total++;
    assert (gnt_idx === exp_x) else begin
      bad++;
      $error("FAIL %s gnt_idx: observed=%0d expected=%0d", tag, gnt_idx, exp_x);
    end
    total++;
    assert (gnt_valid === exp_v) else begin
      bad++;
      $error("FAIL %s gnt_valid: observed=%b expected=%b", tag, gnt_valid, exp_v);
    end
    total++;
    assert (hold_cnt === exp_h) else begin
      bad++;
      $error("FAIL %s hold_cnt: observed=%0d expected=%0d", tag, hold_cnt, exp_h);
    end
    total++;
    assert (state_dbg === exp_v) else begin
      bad++;
      $error("FAIL %s state: observed=%b expected=%b", tag, state_dbg, exp_v);
    end
  endtask

  initial begin
    logic [2:0] rot_exp[8];
    logic [2:0] owner;

`ifdef ARB_PRI8_ROUND_ROBIN_EN
    rot_exp = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
    rot_exp = '{3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7};
`endif

    // reset held with every master requesting
    rst = 1'b1;
    req = 8'hFF;
    step();
    chk("reset_a", 1'b0, 3'd0, 8'd0);
    step();
    chk("reset_b", 1'b0, 3'd0, 8'd0);
    rst = 1'b0;
    req = 8'h00;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("idle_%0d", k), 1'b0, 3'd0, 8'd0);
    end

    // fixed priority and bubble-free handover
    req = 8'b0101_0000;
    step();
    chk("prio_6", 1'b1, 3'd6, 8'd1);
    req = 8'b0001_0000;
    step();
    chk("handover_4", 1'b1, 3'd4, 8'd1);
    req = 8'h00;
    step();
    chk("release_idle", 1'b0, 3'd0, 8'd0);

    // short reset pulse between edges so every build starts the next section from pointer 0
    #2 rst = 1'b1;
    #1 rst = 1'b0;

    // forced release between 7 and 0 with MAX_HOLD=4
    req = 8'b1000_0001;
    for (int k = 0; k < 9; k++) begin
      step();
      owner = (k >= 4 && k < 8) ? 3'd0 : 3'd7;
      chk($sformatf("force_%0d", k), 1'b1, owner, 8'((k % 4) + 1));
    end
    req = 8'h00;
    step();
    chk("force_idle", 1'b0, 3'd0, 8'd0);

    // sole requester is re-granted at timeout
    req = 8'b0000_1000;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("sole_%0d", k), 1'b1, 3'd3, 8'((k % 4) + 1));
    end
    req = 8'h00;
    step();
    chk("sole_idle", 1'b0, 3'd0, 8'd0);

    // async reset mid-grant
    req = 8'b0010_0000;
    step();
    step();
    step();
    chk("pre_rst", 1'b1, 3'd5, 8'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 1'b0, 3'd0, 8'd0);
    #1 rst = 1'b0;
    step();
    chk("post_rst", 1'b1, 3'd5, 8'd1);

    // drop-and-reassert sequence from a fresh reset
    req = 8'h00;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    req = 8'hFF;
    step();
    chk("rot_start", 1'b1, 3'd7, 8'd1);
    owner = 3'd7;
    for (int k = 0; k < 8; k++) begin
      req = 8'hFF & ~(8'b0000_0001 << owner);
      step();
      chk($sformatf("rot_drop_%0d", k), 1'b1, rot_exp[k], 8'd1);
      owner = rot_exp[k];
      req = 8'hFF;
      step();
      chk($sformatf("rot_keep_%0d", k), 1'b1, owner, 8'd2);
    end

    req = 8'h00;
    step();
    chk("final_idle", 1'b0, 3'd0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
